// File: rtl/dds_uart_pkg.sv
// dds_uart_pkg: frame constants, status codes, response FSM states and the CRC-8 (poly 0x07) step
// shared by the command receiver and the response transmitter.
package dds_uart_pkg;
  localparam logic [7:0] FRAME_HEAD = 8'h55;
  localparam logic [7:0] FRAME_TAIL = 8'hAA;
  localparam int RESP_LEN = 6;
  localparam logic [7:0] STS_OK = 8'h00;
  localparam logic [7:0] STS_CRC_ERR = 8'h01;
  localparam logic [7:0] STS_BAD_CMD = 8'h02;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, NEXT} resp_state_t;
  function automatic logic [7:0] crc8_07(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ 8'h07 : {c[6:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one-byte UART serializer, start/d0..d7/stop, LSB first, idle high.
// UART_RESP_PARITY_EN inserts an even-parity bit between d7 and stop.
module uart_tx_byte #(
  parameter int BAUD_CNT_MAX = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       txd
);
`ifdef UART_RESP_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd10;
`else
  localparam logic [3:0] LAST_BIT = 4'd9;
`endif
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        bit_end;
  logic        pbit;
  assign bit_end = busy && baud_cnt == BAUD_LAST;
  // done is combinational so the caller can leave SEND on the very edge the stop bit ends
  assign done = bit_end && bit_cnt == LAST_BIT;
`ifdef UART_RESP_PARITY_EN
  logic parity;
  assign pbit = bit_cnt == 4'd8 ? parity : 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) parity <= 1'b0;
    else if (start && !busy) parity <= ^data;
`else
  assign pbit = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (!busy) begin
      if (start) begin
        busy     <= 1'b1;
        txd      <= 1'b0;
        shreg    <= data;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (bit_end) begin
      baud_cnt <= '0;
      bit_cnt  <= done ? 4'd0 : bit_cnt + 4'd1;
      busy     <= !done;
      txd      <= done ? 1'b1 : bit_cnt < 4'd8 ? shreg[0] : pbit;
      if (bit_cnt < 4'd8) shreg <= {1'b0, shreg[7:1]};
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/uart_resp_tx.sv
// uart_resp_tx: builds the 6-byte response frame 55|func|ch|status|crc8|AA and serializes it.
// Build option UART_RESP_PARITY_EN adds an even-parity bit per byte.
module uart_resp_tx
  import dds_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_func,
  input  logic [7:0] req_ch,
  input  logic [7:0] req_status,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       frame_done
);
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [2:0] LAST_IDX = 3'(RESP_LEN - 1);
  resp_state_t state;
  logic [2:0] idx;
  logic [7:0] func_q, ch_q, sts_q, crc_q, crc_c, tx_byte;
  logic       byte_start, byte_busy, byte_done;
  assign crc_c = crc8_07(crc8_07(crc8_07(8'h00, func_q), ch_q), sts_q);
  always_comb
    tx_byte = idx == 3'd0 ? FRAME_HEAD :
              idx == 3'd1 ? func_q :
              idx == 3'd2 ? ch_q :
              idx == 3'd3 ? sts_q :
              idx == 3'd4 ? crc_q : FRAME_TAIL;
  assign byte_start = state == LOAD && !byte_busy;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      func_q     <= '0;
      ch_q       <= '0;
      sts_q      <= '0;
      crc_q      <= '0;
      req_ready  <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          func_q    <= req_func;
          ch_q      <= req_ch;
          sts_q     <= req_status;
          idx       <= '0;
          req_ready <= 1'b0;
          tx_busy   <= 1'b1;
          state     <= LOAD;
        end
        LOAD: begin
          if (idx == 3'd0) crc_q <= crc_c;
          state <= SEND;
        end
        // frame_done is raised during NEXT so a request seen in that cycle is refused
        SEND: if (byte_done) begin
          state <= NEXT;
          if (idx == LAST_IDX) begin
            frame_done <= 1'b1;
            tx_busy    <= 1'b0;
          end
        end
        NEXT: if (idx == LAST_IDX) begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end else begin
          idx   <= idx + 3'd1;
          state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end
  uart_tx_byte #(.BAUD_CNT_MAX(BAUD_CNT_MAX)) u_tx (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .start (byte_start),
    .data  (tx_byte),
    .busy  (byte_busy),
    .done  (byte_done),
    .txd   (uart_txd)
  );
endmodule
